data_mem_store_buffer: RTL and testbench
========================================

// Module: data_mem_store_buffer
// PURPOSE
//  Data memory for the single-cycle MIPS core; sits directly downstream of the datapath.
//  Takes the ALU result as address and the register-file read port 2 value as store data.
//  Returns the load word to the memtoreg mux. Stores are posted into a small FIFO store
//  buffer and drained into a single-port RAM only in cycles when the CPU is not using memory.
//  Loads see buffered stores through youngest-match forwarding. stall holds the PC when the
//  buffer is full.
// PARAMETERS
//  MEM_WORDS  64  RAM depth in 32-bit words; power of 2; AW = log2(MEM_WORDS)
//  SB_DEPTH   4   store-buffer entries; power of 2, >=2
// PORTS
//  clk         in   1        rising-edge clock
//  reset       in   1        synchronous, active-high reset
//  addr        in   32       byte address (ALU result)
//  write_data  in   32       store data
//  mem_write   in   1        store request this cycle
//  mem_read    in   1        load request this cycle
//  read_data   out  32       load data, combinational
//  stall       out  1        store not accepted this cycle; CPU must hold PC and retry
//  sb_count    out  log2(SB_DEPTH)+1   registered buffer occupancy
//  sb_empty    out  1        sb_count==0
// BEHAVIOUR
//  - Word index idx = addr[AW+1:2]. addr[1:0] and addr[31:AW+2] are ignored, so higher
//    addresses alias modulo MEM_WORDS. There are no byte enables; every access is a full word.
//  - Reset (synchronous): RAM words cleared to 0, head/tail/count cleared, all buffered stores
//    discarded (including those mid-drain). Outputs after reset: sb_count=0, sb_empty=1,
//    stall=0, read_data=0 for any address.
//  - Buffer is a circular FIFO of {idx, data}. Head and tail pointers wrap modulo SB_DEPTH.
//    count is a separate register, so full and empty are unambiguous.
//  - full = (count==SB_DEPTH). stall = mem_write & full, combinational.
//  - Push: at the edge where mem_write & !stall, {idx, write_data} goes to the tail and tail
//    advances.
//  - Port-idle condition: idle = (!mem_read & !mem_write) | stall. A stall cycle counts as
//    idle, so a full buffer always makes progress.
//  - Drain: at the edge where idle & count!=0, RAM[head.idx] <= head.data and head advances.
//    At most one drain per cycle.
//  - Push and drain never coincide: push needs !stall and mem_write, which makes idle=0.
//    count changes by +1 on push, -1 on drain, 0 otherwise.
//  - read_data, combinational, every cycle regardless of mem_read:
//    - if any valid entry matches idx, return the data of the youngest match (closest to tail);
//    - else return RAM[idx].
//  - A store is visible to loads in the cycle after it is accepted. A load in the same cycle
//    as a store is not defined by the ISA.
//  - If mem_read and mem_write are asserted together, the store rule applies and mem_read is
//    ignored for drain gating.
//  - Stores are written to RAM in program order. Same-index entries are all drained; the last
//    one wins.
//  - Implied FSM, derived from count:
//    - EMPTY: count==0.
//    - PARTIAL: count between 1 and SB_DEPTH-1.
//    - FULL: count==SB_DEPTH.
//    - EMPTY->PARTIAL on push. PARTIAL->FULL on push at count SB_DEPTH-1.
//    - FULL->PARTIAL on drain. PARTIAL->EMPTY on drain at count 1.
//    - Any state -> EMPTY on reset.
// TESTING
//  1 reset; mem_read=1, addr=0x10 -> read_data=0, sb_count=0, sb_empty=1, stall=0.
//  2 store 0x20<=0xDEADBEEF, next cycle load 0x20 -> 0xDEADBEEF via forwarding, sb_count=1.
//    One idle cycle -> sb_count=0; load 0x20 again -> 0xDEADBEEF from RAM.
//  3 stores 0x40<=0x1111 then 0x40<=0x2222 back-to-back, then load 0x40 -> 0x2222 (youngest).
//    Idle 2 cycles -> RAM[0x40]=0x2222. Also load 0x140 (alias, MEM_WORDS=64) -> 0x2222.
//  4 4 back-to-back stores to 0x0,0x4,0x8,0xC -> sb_count=4. 5th store to 0x10 -> stall=1
//    for exactly 1 cycle (drain of 0x0), accepted the next cycle, sb_count=4.
//    Idle -> RAM holds all five values.
//  5 pointer wrap: 10 stores with loads interleaved so that count cycles 0..4..0 twice ->
//    all 10 RAM words correct, no lost or duplicated writes.
//  6 3 stores buffered (sb_count=3), assert reset for 1 cycle -> sb_count=0, stall=0.
//    Load of each stored address -> 0.

Source files
------------

// File: rtl/data_mem_store_buffer.sv
// Word-addressed data memory with a posted-store FIFO buffer and youngest-match load forwarding.
// Buffered stores drain into the single-port RAM only in cycles where the CPU leaves the port idle.
module data_mem_store_buffer #(
  parameter int MEM_WORDS = 64,
  parameter int SB_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [31:0]                   addr,
  input  logic [31:0]                   write_data,
  input  logic                          mem_write,
  input  logic                          mem_read,
  output logic [31:0]                   read_data,
  output logic                          stall,
  output logic [$clog2(SB_DEPTH):0]     sb_count,
  output logic                          sb_empty
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   ram     [MEM_WORDS];
  logic [AW-1:0] sb_idx  [SB_DEPTH];
  logic [31:0]   sb_data [SB_DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic [AW-1:0] idx;
  logic          full;
  logic          idle;
  logic          push;
  logic          drain;
  logic          unused_addr;

  // Byte offset and high address bits are ignored, so addresses alias modulo MEM_WORDS.
  assign idx         = addr[AW+1:2];
  assign unused_addr = ^{addr[1:0], addr[31:AW+2]};

  assign full  = (count == CW'(SB_DEPTH));
  assign stall = mem_write & full;
  assign push  = mem_write & ~full;
  // A stall cycle counts as idle so a full buffer always frees an entry.
  assign idle  = (~mem_read & ~mem_write) | stall;
  assign drain = idle & (count != '0);

  assign sb_count = count;
  assign sb_empty = (count == '0);

  // Walk oldest to youngest; a later hit overrides, leaving the youngest match.
  always_comb begin
    logic [PW-1:0] pos;
    logic          hit;
    logic [31:0]   fwd;
    hit = 1'b0;
    fwd = '0;
    pos = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      pos = head + PW'(k);
      if ((CW'(k) < count) && (sb_idx[pos] == idx)) begin
        hit = 1'b1;
        fwd = sb_data[pos];
      end
    end
    read_data = hit ? fwd : ram[idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < MEM_WORDS; i++) begin
        ram[i] <= '0;
      end
    end else if (push) begin
      tail  <= tail + PW'(1);
      count <= count + CW'(1);
    end else if (drain) begin
      ram[sb_idx[head]] <= sb_data[head];
      head  <= head + PW'(1);
      count <= count - CW'(1);
    end
  end

  // Entry payload needs no reset; validity is tracked by head/count.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      sb_idx[tail]  <= idx;
      sb_data[tail] <= write_data;
    end
  end

endmodule

// File: tb/tb_data_mem_store_buffer.sv
// Directed and random checks of data_mem_store_buffer against a queue-based memory model.
module tb_data_mem_store_buffer;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] read_data;
  logic        stall;
  logic [2:0]  sb_count;
  logic        sb_empty;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  logic [31:0] mmem [64];

  data_mem_store_buffer #(.MEM_WORDS(64), .SB_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .addr(addr), .write_data(write_data),
    .mem_write(mem_write), .mem_read(mem_read), .read_data(read_data),
    .stall(stall), .sb_count(sb_count), .sb_empty(sb_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply inputs, let combinational outputs settle, compare against the model.
  task automatic drive(input logic r, input logic we, input logic re,
                       input logic [31:0] a, input logic [31:0] d);
    logic [31:0] exp_rd;
    reset = r; mem_write = we; mem_read = re; addr = a; write_data = d;
    #1;
    if (!r) begin
      exp_rd = mmem[a[7:2]];
      foreach (q[i]) if (q[i].idx == a[7:2]) exp_rd = q[i].data;
      chk("read_data", read_data, exp_rd);
      chk("stall", {31'b0, stall}, {31'b0, (we && q.size() == 4)});
      chk("sb_count", {29'b0, sb_count}, 32'(q.size()));
      chk("sb_empty", {31'b0, sb_empty}, {31'b0, (q.size() == 0)});
    end
  endtask

  // Advance the model by the rules for this cycle, then clock the DUT.
  task automatic tick();
    ent_t e;
    bit   full_m;
    full_m = (q.size() == 4);
    if (reset) begin
      q.delete();
      foreach (mmem[i]) mmem[i] = '0;
    end else if (mem_write && !full_m) begin
      e.idx  = addr[7:2];
      e.data = write_data;
      q.push_back(e);
    end else if (((!mem_read && !mem_write) || (mem_write && full_m)) && q.size() > 0) begin
      e = q.pop_front();
      mmem[e.idx] = e.data;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step(input logic r, input logic we, input logic re,
                      input logic [31:0] a, input logic [31:0] d);
    drive(r, we, re, a, d);
    tick();
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    foreach (mmem[i]) mmem[i] = '0;
    reset = 1'b1; mem_write = 1'b0; mem_read = 1'b0; addr = '0; write_data = '0;
    @(negedge clk);

    // Reset and read-after-reset
    step(1, 0, 0, 0, 0);
    drive(0, 0, 1, 32'h10, 0);
    chk("t1_rd_zero", read_data, 32'h0);
    chk("t1_empty", {31'b0, sb_empty}, 32'h1);
    tick();

    // Forwarding, then drain and read from RAM
    step(0, 1, 0, 32'h20, 32'hDEADBEEF);
    drive(0, 0, 1, 32'h20, 0);
    chk("t2_fwd", read_data, 32'hDEADBEEF);
    chk("t2_count1", {29'b0, sb_count}, 32'd1);
    tick();
    step(0, 0, 0, 0, 0);
    drive(0, 0, 1, 32'h20, 0);
    chk("t2_ram", read_data, 32'hDEADBEEF);
    chk("t2_count0", {29'b0, sb_count}, 32'd0);
    tick();

    // Youngest match wins, and aliasing
    step(0, 1, 0, 32'h40, 32'h1111);
    step(0, 1, 0, 32'h40, 32'h2222);
    drive(0, 0, 1, 32'h40, 0);
    chk("t3_youngest", read_data, 32'h2222);
    tick();
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    drive(0, 0, 1, 32'h140, 0);
    chk("t3_alias", read_data, 32'h2222);
    tick();

    // Fill, one-cycle stall with drain, accept on retry
    for (int i = 0; i < 4; i++) step(0, 1, 0, 32'(i * 4), 32'h100 + 32'(i));
    drive(0, 1, 0, 32'h10, 32'h5555);
    chk("t4_stall", {31'b0, stall}, 32'h1);
    chk("t4_full", {29'b0, sb_count}, 32'd4);
    tick();
    drive(0, 1, 0, 32'h10, 32'h5555);
    chk("t4_accept", {31'b0, stall}, 32'h0);
    tick();
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 32'(i * 4), 0);
      chk("t4_ram", read_data, 32'h100 + 32'(i));
      tick();
    end
    drive(0, 0, 1, 32'h10, 0);
    chk("t4_ram5", read_data, 32'h5555);
    tick();

    // Pointer wrap: occupancy cycles 0..4..0 twice, ten stores in total
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) step(0, 1, 0, 32'h80 + 32'((r * 4 + i) * 4), 32'hA000_0000 + 32'(r * 4 + i));
      for (int i = 0; i < 4; i++) step(0, 0, 1, 32'h80 + 32'((r * 4 + i) * 4), 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
    end
    for (int i = 8; i < 10; i++) step(0, 1, 0, 32'h80 + 32'(i * 4), 32'hA000_0000 + 32'(i));
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 1, 32'h80 + 32'(i * 4), 0);
      chk("t5_wrap", read_data, 32'hA000_0000 + 32'(i));
      tick();
    end

    // Reset discards buffered stores
    for (int i = 0; i < 3; i++) step(0, 1, 0, 32'hC0 + 32'(i * 4), 32'hBEEF_0000 + 32'(i));
    chk("t6_count3", {29'b0, sb_count}, 32'd3);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 32'hC0 + 32'(i * 4), 0);
      chk("t6_cleared", read_data, 32'h0);
      tick();
    end

    // Random traffic over a small index set to exercise matches, aliasing and stalls
    for (int n = 0; n < 400; n++) begin
      a = $urandom();
      a[7:2] = 6'($urandom_range(0, 7));
      d = $urandom();
      case ($urandom_range(0, 3))
        0:       step(0, 1, 0, a, d);
        1:       step(0, 0, 1, a, d);
        2:       step(0, 0, 0, a, d);
        default: step(0, 1, 1, a, d);
      endcase
    end
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 32'(i * 4), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
